lcd_window_sched: RTL and testbench

Arbitrating window scheduler for the 240x135 ST7789 SPI LCD. Two requesters each ask to paint a rectangular window. The block picks one, then emits the CASET/RASET/RAMWR command sequence with panel offsets applied, then streams that requester's RGB565 pixels. Output is a byte stream with D/C flag, sent to the downstream SPI byte serializer, which owns CS/SCLK/MOSI. It sits between the post-init LCD bring-up logic and the pixel producers.

---
 rtl/lcd_window_sched.sv | 256 +++++++++++++++++++++++++
 tb/tb_lcd_window_sched.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_window_sched.sv
// lcd_window_sched: two-requester window scheduler for the 240x135 ST7789 panel.
// Picks a requester, emits CASET/RASET/RAMWR with the panel offsets applied,
// then streams that requester's RGB565 pixels as a D/C-tagged byte stream.
// Build option: define LCD_SCHED_RR_EN for round-robin arbitration;
// otherwise requester 0 always has priority.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate req_valid, validate window, reject or accept
// CMD    | send 11-entry command/address sequence (index 0..10)
// PIXH   | fetch a pixel from the granted requester, offer high byte
// PIXL   | offer low byte, count the pixel down
// FIN    | done/busy already updated on entry; one-cycle turnaround

module lcd_window_sched #(
    parameter int XOFS   = 40,
    parameter int YOFS   = 53,
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 135
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req0_win,
    input  logic [31:0] req1_win,
    output logic [1:0]  req_ready,
    input  logic [15:0] pix0_data,
    input  logic [15:0] pix1_data,
    input  logic [1:0]  pix_valid,
    output logic [1:0]  pix_ready,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        busy,
    output logic        grant,
    output logic [1:0]  done,
    output logic [1:0]  err
);

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;
    localparam logic [3:0] IDX_LAST  = 4'd10;

    localparam logic [8:0] XOFS_L   = 9'(XOFS);
    localparam logic [8:0] YOFS_L   = 9'(YOFS);
    localparam logic [8:0] WIDTH_L  = 9'(WIDTH);
    localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PIXH,
        S_PIXL,
        S_FIN
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [14:0] cnt;
    logic [31:0] win_q;
    logic [7:0]  pix_lo;

    logic        sel;
    logic [31:0] sel_win;
    logic        win_ok;
    logic [8:0]  span_x;
    logic [8:0]  span_y;
    logic [14:0] npix;

    logic [3:0]  idx_nxt;
    logic [8:0]  xs0, xs1, ys0, ys1;
    logic [7:0]  cmd_nxt;
    logic        cmd_dc_nxt;

    logic [15:0] cur_pix;
    logic        cur_pv;

`ifdef LCD_SCHED_RR_EN
    logic        last_grant;

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        sel = 1'b0;
        if (req_valid == 2'b11) begin
            sel = ~last_grant;
        end else begin
            sel = ~req_valid[0];
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is asking.
    always_comb begin
        sel = 1'b0;
        if (!req_valid[0]) begin
            sel = 1'b1;
        end
    end
`endif

    assign sel_win = sel ? req1_win : req0_win;

    // Window must be non-empty and inside the visible area.
    assign win_ok = (sel_win[31:24] <= sel_win[15:8]) &&
                    ({1'b0, sel_win[15:8]} < WIDTH_L) &&
                    (sel_win[23:16] <= sel_win[7:0]) &&
                    ({1'b0, sel_win[7:0]} < HEIGHT_L);

    // Pixel count fits 15 bits for the largest legal window (240*135).
    assign span_x = {1'b0, sel_win[15:8]} - {1'b0, sel_win[31:24]} + 9'd1;
    assign span_y = {1'b0, sel_win[7:0]} - {1'b0, sel_win[23:16]} + 9'd1;
    assign npix   = {6'd0, span_x} * {6'd0, span_y};

    // Panel-offset coordinates, 9-bit sums zero-extended to 16 on the wire.
    assign xs0 = {1'b0, win_q[31:24]} + XOFS_L;
    assign ys0 = {1'b0, win_q[23:16]} + YOFS_L;
    assign xs1 = {1'b0, win_q[15:8]} + XOFS_L;
    assign ys1 = {1'b0, win_q[7:0]} + YOFS_L;

    assign idx_nxt = idx + 4'd1;

    // Next entry of the command sequence, looked up one step ahead so a new
    // byte is ready the cycle after each accept.
    always_comb begin
        cmd_nxt    = 8'h00;
        cmd_dc_nxt = 1'b1;
        case (idx_nxt)
            4'd0:    begin cmd_nxt = CMD_CASET; cmd_dc_nxt = 1'b0; end
            4'd1:    cmd_nxt = {7'd0, xs0[8]};
            4'd2:    cmd_nxt = xs0[7:0];
            4'd3:    cmd_nxt = {7'd0, xs1[8]};
            4'd4:    cmd_nxt = xs1[7:0];
            4'd5:    begin cmd_nxt = CMD_RASET; cmd_dc_nxt = 1'b0; end
            4'd6:    cmd_nxt = {7'd0, ys0[8]};
            4'd7:    cmd_nxt = ys0[7:0];
            4'd8:    cmd_nxt = {7'd0, ys1[8]};
            4'd9:    cmd_nxt = ys1[7:0];
            4'd10:   begin cmd_nxt = CMD_RAMWR; cmd_dc_nxt = 1'b0; end
            default: cmd_nxt = 8'h00;
        endcase
    end

    assign cur_pix = grant ? pix1_data : pix0_data;
    assign cur_pv  = pix_valid[grant];

    // Main sequencer: arbitration, command sequence and pixel streaming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            cnt        <= 15'd0;
            win_q      <= 32'd0;
            pix_lo     <= 8'h00;
            req_ready  <= 2'b00;
            pix_ready  <= 2'b00;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_dc    <= 1'b0;
            busy       <= 1'b0;
            grant      <= 1'b0;
            done       <= 2'b00;
            err        <= 2'b00;
`ifdef LCD_SCHED_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            req_ready <= 2'b00;
            pix_ready <= 2'b00;
            done      <= 2'b00;
            err       <= 2'b00;
            case (state)
                S_IDLE: begin
                    // Skip the cycle right after an accept pulse so a
                    // requester still holding req_valid is not seen twice.
                    if (req_valid != 2'b00 && req_ready == 2'b00) begin
                        req_ready[sel] <= 1'b1;
                        if (!win_ok) begin
                            err[sel] <= 1'b1;
                        end else begin
                            win_q      <= sel_win;
                            cnt        <= npix;
                            grant      <= sel;
                            busy       <= 1'b1;
                            idx        <= 4'd0;
                            byte_valid <= 1'b1;
                            byte_data  <= CMD_CASET;
                            byte_dc    <= 1'b0;
                            state      <= S_CMD;
`ifdef LCD_SCHED_RR_EN
                            last_grant <= sel;
`endif
                        end
                    end
                end
                S_CMD: begin
                    if (byte_valid && byte_ready) begin
                        if (idx == IDX_LAST) begin
                            idx        <= 4'd0;
                            byte_valid <= 1'b0;
                            state      <= S_PIXH;
                        end else begin
                            idx       <= idx_nxt;
                            byte_data <= cmd_nxt;
                            byte_dc   <= cmd_dc_nxt;
                        end
                    end
                end
                S_PIXH: begin
                    if (!byte_valid) begin
                        if (cur_pv) begin
                            pix_ready[grant] <= 1'b1;
                            pix_lo           <= cur_pix[7:0];
                            byte_data        <= cur_pix[15:8];
                            byte_dc          <= 1'b1;
                            byte_valid       <= 1'b1;
                        end
                    end else if (byte_ready) begin
                        byte_data <= pix_lo;
                        state     <= S_PIXL;
                    end
                end
                S_PIXL: begin
                    if (byte_valid && byte_ready) begin
                        cnt <= cnt - 15'd1;
                        if (cnt == 15'd1) begin
                            byte_valid  <= 1'b0;
                            done[grant] <= 1'b1;
                            busy        <= 1'b0;
                            state       <= S_FIN;
                        end else begin
                            state <= S_PIXH;
                            // Fetch the next pixel straight away when it is
                            // already waiting, avoiding a bubble per pixel.
                            if (cur_pv) begin
                                pix_ready[grant] <= 1'b1;
                                pix_lo           <= cur_pix[7:0];
                                byte_data        <= cur_pix[15:8];
                                byte_dc          <= 1'b1;
                            end else begin
                                byte_valid <= 1'b0;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_window_sched.sv
// Scoreboard bench for lcd_window_sched: a window-level model queues the
// expected byte stream, grant order and pixel counts; a monitor checks them.

module tb_lcd_window_sched;

    localparam int XOFS   = 40;
    localparam int YOFS   = 53;
    localparam int WIDTH  = 240;
    localparam int HEIGHT = 135;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req0_win, req1_win;
    logic [1:0]  req_ready;
    logic [15:0] pix0_data, pix1_data;
    logic [1:0]  pix_valid;
    logic [1:0]  pix_ready;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_dc;
    logic        busy;
    logic        grant;
    logic [1:0]  done;
    logic [1:0]  err;

    lcd_window_sched #(.XOFS(XOFS), .YOFS(YOFS), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req0_win(req0_win), .req1_win(req1_win),
        .req_ready(req_ready),
        .pix0_data(pix0_data), .pix1_data(pix1_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_data(byte_data), .byte_dc(byte_dc),
        .busy(busy), .grant(grant), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       dc;
        bit         hi;
        bit         last;
        int         req;
        int         npix;
    } exp_t;

    exp_t        exp_q[$];
    int          gq[$];
    logic [15:0] pq0[$], pq1[$];
    logic [31:0] rq0[$], rq1[$];

    int  n_chk = 0;
    int  n_fail = 0;
    int  wins_done = 0;
    int  pix_cnt = 0;
    int  hi_cnt = 0;
    int  m_last = 1;
    bit  bp_rand = 0;
    bit  pv_rand = 0;
    bit  auto_req = 0;
    bit  err_ok = 0;

    bit         prev_stall = 0;
    bit         prev_bv = 0;
    bit         prev_xfer = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_dc = 1'b0;
    bit         pend_done = 0;
    int         pend_req = 0;
    int         pend_npix = 0;

    function automatic logic [1:0] onehot(input int r);
        return (r == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic void push_exp(input logic [7:0] b, input logic dc, input bit hi,
                                     input bit last, input int r, input int npix);
        exp_t e;
        e.b = b; e.dc = dc; e.hi = hi; e.last = last; e.req = r; e.npix = npix;
        exp_q.push_back(e);
    endfunction

    // Reference model for one accepted window, in grant order.
    function automatic void model_push(input int r, input logic [31:0] w, input int fixed_px);
        int x0, y0, x1, y1, npix, xa, xb, ya, yb;
        logic [7:0]  cmd [11];
        logic [15:0] px;
        x0 = int'(w[31:24]); y0 = int'(w[23:16]);
        x1 = int'(w[15:8]);  y1 = int'(w[7:0]);
        npix = (x1 - x0 + 1) * (y1 - y0 + 1);
        xa = x0 + XOFS; xb = x1 + XOFS; ya = y0 + YOFS; yb = y1 + YOFS;
        cmd = '{8'h2A, 8'(xa / 256), 8'(xa % 256), 8'(xb / 256), 8'(xb % 256),
                8'h2B, 8'(ya / 256), 8'(ya % 256), 8'(yb / 256), 8'(yb % 256), 8'h2C};
        for (int i = 0; i < 11; i++)
            push_exp(cmd[i], (i != 0 && i != 5 && i != 10), 0, 0, r, npix);
        for (int p = 0; p < npix; p++) begin
            px = (fixed_px >= 0) ? 16'(fixed_px) : 16'($urandom);
            if (r == 0) pq0.push_back(px); else pq1.push_back(px);
            push_exp(px[15:8], 1'b1, 1, 0, r, npix);
            push_exp(px[7:0], 1'b1, 0, (p == npix - 1), r, npix);
        end
        gq.push_back(r);
        m_last = r;
    endfunction

    function automatic logic [31:0] rand_win();
        int x0, y0, x1, y1, mx, my;
        x0 = int'($urandom_range(0, WIDTH - 1));
        y0 = int'($urandom_range(0, HEIGHT - 1));
        mx = (WIDTH - 1 - x0) < 5 ? (WIDTH - 1 - x0) : 5;
        my = (HEIGHT - 1 - y0) < 5 ? (HEIGHT - 1 - y0) : 5;
        x1 = x0 + int'($urandom_range(0, mx));
        y1 = y0 + int'($urandom_range(0, my));
        return {8'(x0), 8'(y0), 8'(x1), 8'(y1)};
    endfunction

    // Serializer backpressure, pixel producers and (optionally) requesters.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (pix_ready[0] && pq0.size() > 0) void'(pq0.pop_front());
            if (pix_ready[1] && pq1.size() > 0) void'(pq1.pop_front());
            if (auto_req) begin
                if (req_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
                if (req_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
                req_valid = {rq1.size() > 0, rq0.size() > 0};
                if (rq0.size() > 0) req0_win = rq0[0];
                if (rq1.size() > 0) req1_win = rq1[0];
            end
            byte_ready   = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            pix_valid[0] = (pq0.size() > 0) && (!pv_rand || $urandom_range(0, 3) != 0);
            pix_valid[1] = (pq1.size() > 0) && (!pv_rand || $urandom_range(0, 3) != 0);
            pix0_data    = (pq0.size() > 0) ? pq0[0] : 16'h0000;
            pix1_data    = (pq1.size() > 0) ? pq1[0] : 16'h0000;
        end
    end

    // Monitor: compares every DUT output event against the scoreboard.
    initial begin
        exp_t e;
        logic [1:0] exp_d;
        int g;
        bit xfer;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0; prev_bv = 0; prev_xfer = 0; pend_done = 0;
                pix_cnt = 0; hi_cnt = 0;
                continue;
            end
            if (prev_stall) begin
                n_chk++;
                if (!byte_valid || byte_data !== prev_data || byte_dc !== prev_dc) begin
                    n_fail++;
                    $display("FAIL stall_hold got bv=%b data=%02h dc=%b want bv=1 data=%02h dc=%b",
                             byte_valid, byte_data, byte_dc, prev_data, prev_dc);
                end
            end
            if (pend_done || done != 2'b00) begin
                n_chk++;
                exp_d = pend_done ? onehot(pend_req) : 2'b00;
                if (done !== exp_d || (pend_done && busy)) begin
                    n_fail++;
                    $display("FAIL done_pulse got done=%b busy=%b want done=%b busy=0", done, busy, exp_d);
                end
                if (pend_done) begin
                    n_chk++;
                    if (pix_cnt != pend_npix) begin
                        n_fail++;
                        $display("FAIL pix_ready_count got %0d want %0d", pix_cnt, pend_npix);
                    end
                    wins_done++;
                    pend_done = 0;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (pix_ready[r]) begin
                    n_chk++;
                    pix_cnt++;
                    if (!(busy && grant == 1'(r) && byte_valid && byte_dc && (!prev_bv || prev_xfer) &&
                          exp_q.size() > 0 && exp_q[0].hi && byte_data == exp_q[0].b)) begin
                        n_fail++;
                        $display("FAIL pix_ready_timing r=%0d got grant=%b bv=%b dc=%b data=%02h want grant=%0d with fresh high byte",
                                 r, grant, byte_valid, byte_dc, byte_data, r);
                    end
                end
            end
            if (req_ready != 2'b00 && err == 2'b00) begin
                n_chk++;
                pix_cnt = 0;
                hi_cnt = 0;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL grant_order got req_ready=%b want none", req_ready);
                end else begin
                    g = gq.pop_front();
                    if (req_ready !== onehot(g) || grant !== 1'(g) || !busy) begin
                        n_fail++;
                        $display("FAIL grant_order got req_ready=%b grant=%b busy=%b want req_ready=%b grant=%0d busy=1",
                                 req_ready, grant, busy, onehot(g), g);
                    end
                end
            end
            if (err != 2'b00 && !err_ok) begin
                n_chk++;
                n_fail++;
                $display("FAIL err_unexpected got err=%b want 00", err);
            end
            xfer = byte_valid && byte_ready;
            if (xfer) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL byte_unexpected got data=%02h dc=%b want no byte", byte_data, byte_dc);
                end else begin
                    e = exp_q.pop_front();
                    if (byte_data !== e.b || byte_dc !== e.dc) begin
                        n_fail++;
                        $display("FAIL byte_seq got data=%02h dc=%b want data=%02h dc=%b",
                                 byte_data, byte_dc, e.b, e.dc);
                    end
                    if (e.hi) hi_cnt++;
                    if (e.last) begin
                        pend_done = 1;
                        pend_req = e.req;
                        pend_npix = e.npix;
                    end
                end
            end
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
            prev_dc    = byte_dc;
            prev_bv    = byte_valid;
            prev_xfer  = xfer;
        end
    end

    task automatic check_zero(input string name);
        n_chk++;
        if ({req_ready, pix_ready, byte_valid, byte_data, byte_dc, busy, grant, done, err} !== '0) begin
            n_fail++;
            $display("FAIL %s got rr=%b pr=%b bv=%b data=%02h dc=%b busy=%b grant=%b done=%b err=%b want all 0",
                     name, req_ready, pix_ready, byte_valid, byte_data, byte_dc, busy, grant, done, err);
        end
    endtask

    // Issue one request with the DUT idle and check the N+1 response.
    task automatic single_req(input int r, input logic [31:0] w, input bit ok);
        @(posedge clk); #1;
        if (r == 0) req0_win = w; else req1_win = w;
        req_valid = onehot(r);
        @(posedge clk); #1;
        n_chk++;
        if (ok) begin
            if (req_ready !== onehot(r) || !busy || !byte_valid || byte_data !== 8'h2A ||
                byte_dc !== 1'b0 || err !== 2'b00) begin
                n_fail++;
                $display("FAIL req_accept r=%0d got rr=%b busy=%b bv=%b data=%02h dc=%b err=%b want rr=%b busy=1 bv=1 data=2a dc=0 err=00",
                         r, req_ready, busy, byte_valid, byte_data, byte_dc, err, onehot(r));
            end
        end else begin
            if (req_ready !== onehot(r) || err !== onehot(r) || busy || byte_valid) begin
                n_fail++;
                $display("FAIL req_reject r=%0d got rr=%b err=%b busy=%b bv=%b want rr=%b err=%b busy=0 bv=0",
                         r, req_ready, err, busy, byte_valid, onehot(r), onehot(r));
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (wins_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (wins_done < target) begin
            n_fail++;
            $display("FAIL window_timeout got %0d windows done want %0d", wins_done, target);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int r, target, c0, c1, win_r, n;
        logic [31:0] b0[3], b1[3];

        reset = 1'b1; req_valid = 2'b00; req0_win = '0; req1_win = '0;
        pix0_data = '0; pix1_data = '0; pix_valid = 2'b00; byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        target = 0;

        // Single-pixel window with a fixed pixel value.
        w = {8'd10, 8'd20, 8'd10, 8'd20};
        model_push(0, w, 16'hF800);
        single_req(0, w, 1);
        target++; wait_done(target, 200);

        // Full screen, no backpressure.
        w = {8'd0, 8'd0, 8'd239, 8'd134};
        model_push(0, w, -1);
        single_req(0, w, 1);
        target++; wait_done(target, 70000);

        // Rejected windows.
        err_ok = 1;
        single_req(0, {8'd5, 8'd0, 8'd4, 8'd0}, 0);
        single_req(1, {8'd0, 8'd0, 8'd0, 8'd135}, 0);
        single_req(1, {8'd0, 8'd0, 8'd240, 8'd0}, 0);
        single_req(0, {8'd0, 8'd9, 8'd0, 8'd8}, 0);
        repeat (3) @(posedge clk);
        err_ok = 0;

        // Random windows under random backpressure and pixel stalls.
        bp_rand = 1; pv_rand = 1;
        for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(0, 1));
            w = rand_win();
            model_push(r, w, -1);
            single_req(r, w, 1);
            target++; wait_done(target, 2000);
        end

        // Both requesters pending continuously, three windows each.
        for (int k = 0; k < 3; k++) begin
            b0[k] = rand_win(); b1[k] = rand_win();
            rq0.push_back(b0[k]); rq1.push_back(b1[k]);
        end
        c0 = 0; c1 = 0;
        while (c0 < 3 || c1 < 3) begin
            if (c0 < 3 && c1 < 3) begin
`ifdef LCD_SCHED_RR_EN
                win_r = (m_last == 0) ? 1 : 0;
`else
                win_r = 0;
`endif
            end else begin
                win_r = (c0 < 3) ? 0 : 1;
            end
            if (win_r == 0) begin model_push(0, b0[c0], -1); c0++; end
            else            begin model_push(1, b1[c1], -1); c1++; end
        end
        @(posedge clk); #1;
        auto_req = 1;
        target += 6; wait_done(target, 6000);
        auto_req = 0;
        req_valid = 2'b00;

        // Reset during the low byte of pixel 100, then a clean restart.
        bp_rand = 0; pv_rand = 0;
        w = {8'd0, 8'd0, 8'd19, 8'd19};
        model_push(0, w, -1);
        single_req(0, w, 1);
        n = 0;
        while (hi_cnt < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (hi_cnt < 100) begin
            n_fail++;
            $display("FAIL reach_pixel100 got %0d high bytes want 100", hi_cnt);
        end
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_zero("reset_midwindow");
        exp_q.delete(); gq.delete(); pq0.delete(); pq1.delete();
        m_last = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero("reset_release");
        w = {8'd100, 8'd50, 8'd102, 8'd51};
        model_push(0, w, -1);
        single_req(0, w, 1);
        target++; wait_done(target, 500);

        repeat (3) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0 || gq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d bytes %0d grants left want 0 0", exp_q.size(), gq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
